// File: rtl/fp16_pkg.sv
// Shared FP16 field widths, special encodings and accumulator state type,
// imported by the FP16 multiplier and the dot-product accumulator.
package fp16_pkg;

  localparam int FP16_EXP_W = 5;
  localparam int FP16_MAN_W = 10;
  localparam int FP16_BIAS  = 15;

  localparam logic [15:0] FP16_PZERO = 16'h0000;
  localparam logic [15:0] FP16_PINF  = 16'h7C00;
  localparam logic [15:0] FP16_NINF  = 16'hFC00;
  localparam logic [15:0] FP16_QNAN  = 16'h7E00;

  typedef enum logic {
    ST_ACC,
    ST_FULL
  } accum_state_t;

endpackage

// File: rtl/fp16_add.sv
// Combinational FP16 adder: flush-to-zero inputs and outputs, guard/round/sticky
// alignment with round-to-nearest-even, canonical qNaN for invalid operations.
module fp16_add
  import fp16_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] y
);

  localparam logic signed [6:0] EMAX = 7'(2 * FP16_BIAS + 1);

  logic                  sa, sb;
  logic [FP16_EXP_W-1:0] ea, eb;
  logic [FP16_MAN_W-1:0] ma, mb;
  logic                  za, zb, ia, ib, na, nb;

  assign sa = a[15];
  assign sb = b[15];
  assign ea = a[14 -: FP16_EXP_W];
  assign eb = b[14 -: FP16_EXP_W];
  assign ma = a[FP16_MAN_W-1:0];
  assign mb = b[FP16_MAN_W-1:0];
  assign za = (ea == '0);
  assign zb = (eb == '0);
  assign ia = (ea == '1) && (ma == '0);
  assign ib = (eb == '1) && (mb == '0);
  assign na = (ea == '1) && (ma != '0);
  assign nb = (eb == '1) && (mb != '0);

  logic               swap, sx, sy;
  logic [4:0]         ex, ey, shamt;
  logic [10:0]        sigx, sigy;
  logic [42:0]        ywide;
  logic [13:0]        xal, yal, norm;
  logic [14:0]        raw;
  logic [3:0]         lz;
  logic [11:0]        rsig;
  logic               rup;
  logic signed [6:0]  eres, efin;
  logic [15:0]        gen;

  // The larger magnitude operand is x, so the subtract path never goes negative
  // and the result sign is simply the sign of x.
  always_comb begin
    swap  = {eb, mb} > {ea, ma};
    sx    = swap ? sb : sa;
    sy    = swap ? sa : sb;
    ex    = swap ? eb : ea;
    ey    = swap ? ea : eb;
    sigx  = {1'b1, (swap ? mb : ma)};
    sigy  = {1'b1, (swap ? ma : mb)};
    shamt = ex - ey;
    ywide = {sigy, 32'b0} >> shamt;
    xal   = {sigx, 3'b000};
    yal   = {ywide[42:30], |ywide[29:0]};
    raw   = (sx == sy) ? ({1'b0, xal} + {1'b0, yal}) : ({1'b0, xal} - {1'b0, yal});

    lz = 4'd0;
    for (int i = 0; i < 14; i++) begin
      if (raw[i]) lz = 4'(13 - i);
    end

    eres = $signed({2'b00, ex});
    norm = raw[13:0];
    if (raw[14]) begin
      norm = {raw[14:2], raw[1] | raw[0]};
      eres = eres + 7'sd1;
    end else begin
      norm = raw[13:0] << lz;
      eres = eres - $signed({3'b000, lz});
    end

    rup  = norm[2] & (norm[1] | norm[0] | norm[3]);
    rsig = {1'b0, norm[13:3]} + {11'b0, rup};
    efin = rsig[11] ? (eres + 7'sd1) : eres;

    if (raw == '0 || efin < 7'sd1) begin
      gen = FP16_PZERO;
    end else if (efin >= EMAX) begin
      gen = sx ? FP16_NINF : FP16_PINF;
    end else begin
      gen = {sx, efin[4:0], (rsig[11] ? rsig[10:1] : rsig[9:0])};
    end
  end

  // Specials take priority over the normal datapath result.
  always_comb begin
    y = gen;
    if (na || nb) begin
      y = FP16_QNAN;
    end else if (ia && ib) begin
      y = (sa == sb) ? a : FP16_QNAN;
    end else if (ia) begin
      y = a;
    end else if (ib) begin
      y = b;
    end else if (za && zb) begin
      y = {sa & sb, 15'b0};
    end else if (za) begin
      y = b;
    end else if (zb) begin
      y = a;
    end
  end

endmodule

// File: rtl/fp16_dot_accum.sv
// Streaming FP16 dot-product accumulator: sums VEC_LEN consecutive products and
// presents each result behind a single-entry valid/ready output register.
module fp16_dot_accum
  import fp16_pkg::*;
#(
  parameter int VEC_LEN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data
);

  localparam logic [3:0] LAST = 4'(VEC_LEN - 1);

  accum_state_t state, state_nxt;
  logic [15:0]  acc, add_a, sum;
  logic [3:0]   cnt;
  logic         accept, last;

  assign out_valid = (state == ST_FULL);
  assign in_ready  = (state == ST_ACC) || out_ready;
  assign accept    = in_valid && in_ready;
  assign last      = (cnt == LAST);
  assign add_a     = (cnt == 4'd0) ? FP16_PZERO : acc;

  fp16_add u_add (
    .a (add_a),
    .b (in_data),
    .y (sum)
  );

  always_ff @(posedge clk) begin
    if (!rst) state <= ST_ACC;
    else      state <= state_nxt;
  end

  // A completing vector keeps the output full even while the old result drains.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_ACC:  if (accept && last) state_nxt = ST_FULL;
      ST_FULL: begin
        if (accept && last)  state_nxt = ST_FULL;
        else if (out_ready)  state_nxt = ST_ACC;
      end
      default: state_nxt = ST_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc      <= FP16_PZERO;
      cnt      <= 4'd0;
      out_data <= FP16_PZERO;
    end else if (accept) begin
      if (last) begin
        out_data <= sum;
        acc      <= FP16_PZERO;
        cnt      <= 4'd0;
      end else begin
        acc <= sum;
        cnt <= cnt + 4'd1;
      end
    end
  end

endmodule

// File: doc/fp16_dot_accum.md
# fp16_dot_accum

Streaming FP16 accumulator that sits directly downstream of `fp16mult` in the vertex datapath. It consumes one FP16 product per accepted cycle and sums each group of `VEC_LEN` consecutive products into one FP16 dot-product result, such as one component of a 4×4 matrix × vertex transform. Results are presented behind a single-entry valid/ready output register. The block stalls the multiplier stream when that register cannot drain.

## Interface
- `VEC_LEN`, default 4: products per dot product, legal range 2..16.
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  `in_data` carries a product.
- `in_ready`  out  1  the block accepts `in_data` this cycle.
- `in_data`  in  16  FP16 product, taken from the `fp16mult` `x` output.
- `out_valid`  out  1  `out_data` holds a completed dot product.
- `out_ready`  in  1  the consumer takes `out_data` this cycle.
- `out_data`  out  16  FP16 sum of the last `VEC_LEN` accepted products.

## Operation
- An input is accepted when `in_valid && in_ready`.
- `in_ready = !out_valid || out_ready`. It is a combinational function of register state and `out_ready` only, never of `in_valid`.
- State registers:
  - `acc[15:0]`, the running sum.
  - `cnt[3:0]`, the element index.
  - `out_data`.
  - `out_valid`.
- FSM with two states:
  - ACC: `out_valid` = 0.
  - FULL: `out_valid` = 1.
  - ACC→FULL when the last element is accepted.
  - FULL→ACC when `out_ready` is high and no last element is accepted in the same cycle.
  - FULL→FULL when both happen in the same cycle. `out_data` is replaced with the new sum and nothing is lost.
- On acceptance, `sum = fp16_add(cnt==0 ? 16'h0000 : acc, in_data)`.
  - If `cnt == VEC_LEN-1`: `out_data <= sum`, `out_valid <= 1`, `cnt <= 0`, `acc <= 0`.
  - Otherwise: `acc <= sum`, `cnt <= cnt+1`.
- FP16 add rules:
  - Subnormal inputs are flushed to signed zero.
  - Alignment uses a guard, round and sticky bit, rounded to nearest-even.
  - A result whose exponent underflows flushes to +0.
  - Exponent overflow gives a correctly signed infinity (`7C00`/`FC00`).
  - Any NaN input, or +inf + −inf, gives canonical qNaN `7E00`.
  - inf + finite gives that inf.
  - Exact cancellation gives +0.
- Accumulation is sequential and left-to-right in acceptance order, so results are bit-exact to a serial FP16 reference using these rules.

## Timing
- Reset, at a rising edge with `rst`=0:
  - `out_valid` = 0, `out_data` = `16'h0000`, `acc` = 0, `cnt` = 0.
  - `in_ready` = 1 from the first cycle after reset.
- Throughput: one product per cycle while `out_ready` is held high or the output register is empty.
- Latency: `out_valid` rises on the clock edge that accepts element `VEC_LEN-1`, so `out_data` is visible in the next cycle.
- `out_data` and `out_valid` are stable while `out_valid && !out_ready`. No input is accepted in that condition.
- Reset asserted mid-vector discards the partial sum and any pending output. Counting restarts at element 0.
- `cnt` wraps only via the last-element rule and never exceeds `VEC_LEN-1`.

## Structure
- Package `fp16_pkg` holds:
  - field widths (`FP16_EXP_W`=5, `FP16_MAN_W`=10);
  - `FP16_BIAS`=15;
  - constants `FP16_PZERO`=`0000`, `FP16_PINF`=`7C00`, `FP16_NINF`=`FC00`, `FP16_QNAN`=`7E00`.
- Both `fp16mult` and this block import `fp16_pkg`.
- One sub-module: `fp16_add`, purely combinational, with inputs `a`, `b` and output `y`, all 16 bits. It implements the add rules above and is unit-tested on its own.
- `fp16_dot_accum` contains only the FSM, counter, accumulator and output register.

## Test plan
- Basic sum, `VEC_LEN`=4, `out_ready`=1: feed `3C00`, `4000`, `4200`, `4400` back-to-back → `out_valid` for exactly 1 cycle with `out_data`=`4900` (10.0). `in_ready` stays 1 throughout.
- Cancellation and rounding:
  - `4000`, `C000`, `3C00`, `0000` → `3C00`.
  - `3C00`, `1000`, `0000`, `0000` → `3C00` (tie rounds to even).
  - `3C00`, `1400`, `1000`, `0000` → `3C02`.
- Specials:
  - `7BFF`, `7BFF`, `0000`, `0000` → `7C00`.
  - `7C00`, `FC00`, `3C00`, `3C00` → `7E00`.
  - `0001`, `0000`, `0000`, `0000` → `0000` (subnormal flushed).
- Backpressure: hold `out_ready`=0 after the first result and feed a second vector → `in_ready`=0 and `out_data` held. Raise `out_ready` → exactly one result consumed, `in_ready`=1 the same cycle, and the second vector completes correctly.
- Simultaneous drain and complete: with `out_valid`=1, assert `out_ready` in the cycle the next vector's last element is accepted → `out_valid` stays 1 and `out_data` updates to the new sum with no bubble.
- Reset mid-vector: accept 2 elements, pull `rst` low for 1 cycle, then feed `3C00`×4 → `out_data`=`4400` (4.0). No stale partial sum appears.
